enable_prescaler: RTL

Programmable enable-pulse generator placed directly upstream of the free-running counter stage. It produces a single-cycle `enable_o` strobe every `cfg_div+1` clock cycles, so downstream counters advance at a divided rate. Two modes: continuous (runs until stopped) or one-shot (emits exactly `cfg_pulses` strobes, then signals `done`). Configuration uses a valid/ready handshake that is accepted only while idle.

---
 rtl/enable_prescaler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/enable_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : enable_prescaler
//  Description : Programmable enable-strobe generator. Emits a one-cycle
//                enable_o every (div+1) clocks in continuous mode, or exactly
//                'pulses' strobes followed by a one-cycle done in one-shot
//                mode. Configuration is taken by valid/ready only while idle.
//  Revision    : 1.0  initial release
// ============================================================================
module enable_prescaler #(
  parameter int DIV_WIDTH   = 16,
  parameter int PULSE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [DIV_WIDTH-1:0]   cfg_div,
  input  logic                   cfg_oneshot,
  input  logic [PULSE_WIDTH-1:0] cfg_pulses,
  input  logic                   start,
  input  logic                   stop,
  output logic                   enable_o,
  output logic                   busy,
  output logic                   done,
  output logic [PULSE_WIDTH-1:0] remaining
);

  localparam logic [DIV_WIDTH-1:0]   c_DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [PULSE_WIDTH-1:0] c_PULSE_ONE = PULSE_WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [DIV_WIDTH-1:0]   r_cnt;
  logic [DIV_WIDTH-1:0]   r_div;
  logic                   r_oneshot;
  logic [PULSE_WIDTH-1:0] r_pulses;
  logic [PULSE_WIDTH-1:0] r_remaining;
  logic                   r_done;

  logic                   w_cfg_hs;
  logic [DIV_WIDTH-1:0]   w_div_eff;
  logic                   w_oneshot_eff;
  logic [PULSE_WIDTH-1:0] w_pulses_eff;
  logic                   w_strobe;

  // Handshake and effective configuration: a configuration accepted in the
  // same cycle as start takes effect immediately, bypassing the registers.
  always_comb begin
    w_cfg_hs      = cfg_valid && (r_state == IDLE);
    w_div_eff     = w_cfg_hs ? cfg_div     : r_div;
    w_oneshot_eff = w_cfg_hs ? cfg_oneshot : r_oneshot;
    w_pulses_eff  = w_cfg_hs ? cfg_pulses  : r_pulses;
    w_strobe      = (r_state == RUN) && (r_cnt == '0);
  end

  // Configuration registers load only on an accepted handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div     <= '0;
      r_oneshot <= 1'b0;
      r_pulses  <= '0;
    end else if (w_cfg_hs) begin
      r_div     <= cfg_div;
      r_oneshot <= cfg_oneshot;
      r_pulses  <= cfg_pulses;
    end
  end

  // Control FSM with prescale counter, pulse budget and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !stop) begin
            if (w_oneshot_eff && (w_pulses_eff == '0)) begin
              // Empty one-shot: nothing to emit, report completion directly.
              r_done <= 1'b1;
            end else begin
              r_state     <= RUN;
              r_cnt       <= w_div_eff;
              r_remaining <= w_oneshot_eff ? w_pulses_eff : '0;
            end
          end
        end
        RUN: begin
          if (w_strobe) begin
            r_cnt <= r_div;
          end else begin
            r_cnt <= r_cnt - c_DIV_ONE;
          end

          if (stop) begin
            // Abort: the strobe decoded this cycle still goes out, but the
            // run ends without a done indication.
            r_state     <= IDLE;
            r_remaining <= '0;
          end else if (w_strobe && r_oneshot) begin
            r_remaining <= r_remaining - c_PULSE_ONE;
            if (r_remaining == c_PULSE_ONE) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded purely from registers.
  always_comb begin
    cfg_ready = (r_state == IDLE);
    busy      = (r_state == RUN);
    enable_o  = w_strobe;
    done      = r_done;
    remaining = r_remaining;
  end

endmodule
`default_nettype wire
